// File: rtl/uart_rx_fifo_if.sv
// Purpose: receive-side character stream from the UART receiver to its consumer.
// Latency: n/a (signal bundle only).
// Backpressure: valid/ready; the head entry holds while m_valid && !m_ready.
//
// Signals:
//   m_data  - head character, LSB = first bit on the line, unused upper bits 0
//   m_perr  - parity error flag of the head character
//   m_ferr  - framing error flag of the head character
//   m_valid - a character is available
//   m_ready - consumer takes the head character this cycle
interface uart_rx_fifo_if;
    logic [7:0] m_data;
    logic       m_perr;
    logic       m_ferr;
    logic       m_valid;
    logic       m_ready;

    modport master (
        output m_data,
        output m_perr,
        output m_ferr,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_perr,
        input  m_ferr,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Purpose: parametrised UART receiver (5..8 data bits, none/odd/even parity, 1/2 stop) feeding a small FWFT FIFO.
// Latency: character visible one cycle after its final stop-bit sample (FIFO empty case).
// Backpressure: FIFO absorbs FIFO_DEPTH characters; a frame arriving while full is dropped and sets overrun.
//
// Ports:
//   clk, nreset     - clock, asynchronous active-low reset
//   rx              - asynchronous serial line, idles high
//   m               - character stream (data, perr, ferr, valid/ready)
//   overrun/clr_err - sticky dropped-frame flag and its clear
//   break_det       - one-cycle pulse when a line break is recognised
//   busy            - receiver is inside a frame (or waiting for the line to return high)
module uart_rx_fifo #(
    parameter int CLK_DIV     = 434,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           rx,
    uart_rx_fifo_if.master m,
    output logic           overrun,
    input  logic           clr_err,
    output logic           break_det,
    output logic           busy
);

    localparam int CW    = $clog2(CLK_DIV);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;

    localparam logic [CW-1:0]    HALF_M1   = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0]    FULL_M1   = CW'(CLK_DIV - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    // ------------------------------------------------------------------
    // rx synchroniser; resets to the idle (high) level
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    idx;           // data-bit / stop-bit index
    logic [7:0]    shreg;         // received data, upper unused bits stay 0
    logic          par_bit;
    logic          any_one;       // a data or parity sample was 1 (rules out a break)
    logic          stop_low_all;  // every earlier stop sample was 0
    logic          stop_ferr;     // an earlier stop sample was 0

    logic       tick;
    logic       last_stop;
    logic       stop_ferr_f;
    logic       stop_zero_f;
    logic       is_break;
    logic       push;
    logic       xor_all;
    logic       perr;
    logic [9:0] push_dat;

    assign tick        = (bit_cnt == FULL_M1);
    assign last_stop   = (state == S_STOP) && tick && (idx == STOP_LAST);
    // Fold the current stop sample in so the push happens on the sample cycle itself.
    assign stop_ferr_f = stop_ferr | ~rx_s;
    assign stop_zero_f = stop_low_all & ~rx_s;
    assign is_break    = last_stop && !any_one && stop_zero_f;
    assign push        = last_stop && !is_break;
    assign xor_all     = (^shreg) ^ par_bit;
    assign perr        = (PARITY == 0) ? 1'b0 :
                         (PARITY == 1) ? ~xor_all : xor_all;
    assign push_dat    = {shreg, perr, stop_ferr_f};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state        <= S_IDLE;
            bit_cnt      <= '0;
            idx          <= '0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            any_one      <= 1'b0;
            stop_low_all <= 1'b1;
            stop_ferr    <= 1'b0;
            break_det    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            break_det <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state   <= S_START;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end

                S_START: begin
                    if (bit_cnt == HALF_M1) begin
                        bit_cnt <= '0;
                        if (rx_s) begin
                            // Glitch, not a start bit.
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state        <= S_DATA;
                            idx          <= '0;
                            shreg        <= '0;
                            par_bit      <= 1'b0;
                            any_one      <= 1'b0;
                            stop_low_all <= 1'b1;
                            stop_ferr    <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (tick) begin
                        bit_cnt    <= '0;
                        shreg[idx] <= rx_s;
                        any_one    <= any_one | rx_s;
                        if (idx == DATA_LAST) begin
                            idx   <= '0;
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (tick) begin
                        bit_cnt <= '0;
                        par_bit <= rx_s;
                        any_one <= any_one | rx_s;
                        idx     <= '0;
                        state   <= S_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (tick) begin
                        bit_cnt <= '0;
                        if (idx == STOP_LAST) begin
                            // Leaving mid-stop-bit lets a back-to-back start edge be caught.
                            if (is_break) begin
                                break_det <= 1'b1;
                                state     <= S_WAIT_HIGH;
                            end else if (stop_ferr_f) begin
                                state <= S_WAIT_HIGH;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            idx          <= idx + 1'b1;
                            stop_ferr    <= stop_ferr_f;
                            stop_low_all <= stop_zero_f;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                S_WAIT_HIGH: begin
                    // A stuck-low line must not be re-read as a stream of frames.
                    if (rx_s) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // First-word fall-through FIFO
    // ------------------------------------------------------------------
    logic [9:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             valid;
    logic             full;
    logic             pop;
    logic             wr_en;
    logic             drop;
    logic [9:0]       head;

    assign valid = (count != '0);
    assign full  = (count == DEPTH_C);
    assign pop   = valid && m.m_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A drop in the same cycle as clr_err wins.
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

    // Outputs read as zero whenever the FIFO is empty.
    assign m.m_valid = valid;
    assign m.m_data  = valid ? head[9:2] : 8'h00;
    assign m.m_perr  = valid ? head[1]   : 1'b0;
    assign m.m_ferr  = valid ? head[0]   : 1'b0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose: directed self-checking bench for uart_rx_fifo (8N1 and 7E2 instances, CLK_DIV = 16).
// Latency: n/a.
// Backpressure: bench drives m_ready directly to exercise hold, drain and overrun.
module tb_uart_rx_fifo;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic rx8 = 1'b1;
    logic rx7 = 1'b1;
    logic clr8 = 1'b0;
    logic clr7 = 1'b0;
    logic ovr8, ovr7, brk8, brk7, busy8, busy7;

    uart_rx_fifo_if if8 ();
    uart_rx_fifo_if if7 ();

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .SYNC_STAGES(2)
    ) u_8n1 (
        .clk(clk), .nreset(nreset), .rx(rx8), .m(if8.master),
        .overrun(ovr8), .clr_err(clr8), .break_det(brk8), .busy(busy8)
    );

    uart_rx_fifo #(
        .CLK_DIV(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4), .SYNC_STAGES(2)
    ) u_7e2 (
        .clk(clk), .nreset(nreset), .rx(rx7), .m(if7.master),
        .overrun(ovr7), .clr_err(clr7), .break_det(brk7), .busy(busy7)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int brk_cnt = 0;
    int t_busy = -1;
    int t_valid = -1;
    bit log_en = 1'b0;
    bit lat_arm = 1'b0;
    logic [9:0] pop_q [$];

    always @(posedge clk) cyc++;

    // Observe between edges, after the negedge stimulus has settled.
    always @(negedge clk) begin
        #2;
        if (brk8) brk_cnt++;
        if (log_en && if8.m_valid && if8.m_ready)
            pop_q.push_back({if8.m_data, if8.m_perr, if8.m_ferr});
        if (lat_arm) begin
            if (busy8 && t_busy < 0) t_busy = cyc;
            if (if8.m_valid && t_valid < 0) t_valid = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive n line bits, bits[0] first, each held one bit time.
    task automatic send(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) rx8 = bits[i];
            else          rx7 = bits[i];
            wait_cyc(16);
        end
    endtask

    task automatic frame8(input logic [7:0] d, input logic stop);
        send(0, {6'b0, stop, d, 1'b0}, 10);
    endtask

    task automatic pop(input int sel);
        if (sel == 0) if8.m_ready = 1'b1;
        else          if7.m_ready = 1'b1;
        wait_cyc(1);
        if8.m_ready = 1'b0;
        if7.m_ready = 1'b0;
    endtask

    initial begin
        if8.m_ready = 1'b0;
        if7.m_ready = 1'b0;

        // ---- reset state ----
        wait_cyc(3);
        chk("rst_valid", {31'b0, if8.m_valid}, 0);
        chk("rst_data", {24'b0, if8.m_data}, 0);
        chk("rst_perr", {31'b0, if8.m_perr}, 0);
        chk("rst_ferr", {31'b0, if8.m_ferr}, 0);
        chk("rst_overrun", {31'b0, ovr8}, 0);
        chk("rst_break", {31'b0, brk8}, 0);
        chk("rst_busy", {31'b0, busy8}, 0);
        chk("rst_valid7", {31'b0, if7.m_valid}, 0);
        nreset = 1'b1;
        wait_cyc(3);

        // ---- 8N1 back-to-back, consumer always ready ----
        if8.m_ready = 1'b1;
        log_en = 1'b1;
        lat_arm = 1'b1;
        frame8(8'hA5, 1'b1);
        frame8(8'h3C, 1'b1);
        rx8 = 1'b1;
        wait_cyc(40);
        log_en = 1'b0;
        lat_arm = 1'b0;
        if8.m_ready = 1'b0;
        chk("b2b_pops", pop_q.size(), 2);
        chk("b2b_first", {22'b0, pop_q[0]}, {22'b0, 8'hA5, 2'b00});
        chk("b2b_second", {22'b0, pop_q[1]}, {22'b0, 8'h3C, 2'b00});
        // busy rises in T0+1, m_valid in T0+8+9*16+1.
        chk("first_valid_latency", t_valid - t_busy, 152);
        chk("b2b_drained", {31'b0, if8.m_valid}, 0);
        chk("b2b_idle", {31'b0, busy8}, 0);

        // ---- 7E2: 0x41 with good parity, then inverted parity ----
        send(1, {5'b0, 2'b11, 1'b0, 7'h41, 1'b0}, 11);
        send(1, {5'b0, 2'b11, 1'b1, 7'h41, 1'b0}, 11);
        rx7 = 1'b1;
        wait_cyc(20);
        chk("7e2_valid", {31'b0, if7.m_valid}, 1);
        chk("7e2_data0", {24'b0, if7.m_data}, 32'h41);
        chk("7e2_perr0", {31'b0, if7.m_perr}, 0);
        chk("7e2_ferr0", {31'b0, if7.m_ferr}, 0);
        pop(1);
        chk("7e2_data1", {24'b0, if7.m_data}, 32'h41);
        chk("7e2_perr1", {31'b0, if7.m_perr}, 1);
        chk("7e2_bit7", {31'b0, if7.m_data[7]}, 0);
        pop(1);
        chk("7e2_empty", {31'b0, if7.m_valid}, 0);

        // ---- 5-cycle glitch: false start ----
        rx8 = 1'b0;
        wait_cyc(5);
        rx8 = 1'b1;
        wait_cyc(1);
        chk("glitch_busy_up", {31'b0, busy8}, 1);
        wait_cyc(30);
        chk("glitch_busy_down", {31'b0, busy8}, 0);
        chk("glitch_no_push", {31'b0, if8.m_valid}, 0);

        // ---- framing error: 0x55 with stop = 0, line left low ----
        frame8(8'h55, 1'b0);
        wait_cyc(48);
        chk("ferr_wait_high", {31'b0, busy8}, 1);
        chk("ferr_valid", {31'b0, if8.m_valid}, 1);
        chk("ferr_data", {24'b0, if8.m_data}, 32'h55);
        chk("ferr_flag", {31'b0, if8.m_ferr}, 1);
        chk("ferr_perr", {31'b0, if8.m_perr}, 0);
        rx8 = 1'b1;
        wait_cyc(5);
        chk("ferr_release", {31'b0, busy8}, 0);
        pop(0);
        chk("ferr_no_break", brk_cnt, 0);

        // ---- break: line low for three frame times ----
        rx8 = 1'b0;
        wait_cyc(480);
        chk("brk_busy", {31'b0, busy8}, 1);
        chk("brk_pulses", brk_cnt, 1);
        chk("brk_no_push", {31'b0, if8.m_valid}, 0);
        rx8 = 1'b1;
        wait_cyc(20);
        chk("brk_release", {31'b0, busy8}, 0);
        frame8(8'h3C, 1'b1);
        rx8 = 1'b1;
        wait_cyc(10);
        chk("brk_resume_data", {24'b0, if8.m_data}, 32'h3C);
        chk("brk_resume_valid", {31'b0, if8.m_valid}, 1);
        pop(0);
        chk("brk_pulses_after", brk_cnt, 1);

        // ---- overrun: six frames into a 4-deep FIFO ----
        for (int i = 1; i <= 6; i++) frame8(8'(i * 17), 1'b1);
        rx8 = 1'b1;
        wait_cyc(10);
        chk("ovr_set", {31'b0, ovr8}, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("ovr_valid", {31'b0, if8.m_valid}, 1);
            chk("ovr_drain", {24'b0, if8.m_data}, 32'(i * 17));
            pop(0);
        end
        chk("ovr_empty", {31'b0, if8.m_valid}, 0);
        chk("ovr_sticky", {31'b0, ovr8}, 1);
        clr8 = 1'b1;
        wait_cyc(1);
        clr8 = 1'b0;
        chk("ovr_clear", {31'b0, ovr8}, 0);

        // ---- reset in the 4th data bit, with a character already queued ----
        frame8(8'h5A, 1'b1);
        rx8 = 1'b1;
        wait_cyc(10);
        chk("mid_pre_valid", {31'b0, if8.m_valid}, 1);
        rx8 = 1'b0;
        wait_cyc(16);
        rx8 = 1'b1;
        wait_cyc(3 * 16 + 8);
        nreset = 1'b0;
        wait_cyc(2);
        chk("mid_rst_valid", {31'b0, if8.m_valid}, 0);
        chk("mid_rst_data", {24'b0, if8.m_data}, 0);
        chk("mid_rst_flags", {30'b0, if8.m_perr, if8.m_ferr}, 0);
        chk("mid_rst_misc", {29'b0, ovr8, brk8, busy8}, 0);
        nreset = 1'b1;
        wait_cyc(200);
        chk("mid_post_valid", {31'b0, if8.m_valid}, 0);
        chk("mid_post_busy", {31'b0, busy8}, 0);
        frame8(8'h7E, 1'b1);
        rx8 = 1'b1;
        wait_cyc(10);
        chk("mid_7e_valid", {31'b0, if8.m_valid}, 1);
        chk("mid_7e_data", {24'b0, if8.m_data}, 32'h7E);
        chk("mid_7e_flags", {30'b0, if8.m_perr, if8.m_ferr}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
